sram_arb: RTL and testbench

- Round-robin arbiter that shares one sram_top instance (4K x 64, byte write mask, 1-cycle read latency) between NREQ requesters.
- Typical requesters: weight/feature loader (writes), PE array fetch (reads), output writeback (writes).
- Drives the SRAM cs/we/wem/addr/din pins and routes read data back to the requester that issued the read.
- Sits between the accelerator datapath masters and the sram_top wrapper.

---
 rtl/sram_arb.sv | 164 ++++++++++++++++
 tb/tb_sram_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb.sv
// sram_arb: round-robin arbiter sharing one sram_top port (1-cycle read latency)
// among NREQ requesters, with read data routed back to the issuing requester.
// Optional build macro SRAM_ARB_RDATA_REG_EN registers the read data path,
// moving the response from T+1 to T+2 after the accept cycle T.
module sram_arb #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned DW   = 64,
   parameter int unsigned MW   = 8,
   parameter int unsigned AW   = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0]      req_we,
   input  logic [NREQ*MW-1:0]   req_wem,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_wdata,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [DW-1:0]        rsp_rdata,
   output logic                 sram_cs,
   output logic                 sram_we,
   output logic [MW-1:0]        sram_wem,
   output logic [AW-1:0]        sram_addr,
   output logic [DW-1:0]        sram_din,
   input  logic [DW-1:0]        sram_dout
);

   // Requester index width, plus one spare bit for modulo arithmetic.
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = IW + 1;

   logic            en;
   logic [IW-1:0]   ptr;
   logic            gnt_found;
   logic [IW-1:0]   gnt_idx;
   logic            accept;
   logic            rd_issue;
   logic [CW-1:0]   ptr_inc;
   logic            rd_pend;
   logic [IW-1:0]   rd_id;

   logic [MW-1:0]   wem_a   [NREQ];
   logic [AW-1:0]   addr_a  [NREQ];
   logic [DW-1:0]   wdata_a [NREQ];

   // Split the flattened per-requester payload buses into indexable arrays.
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign wem_a[g]   = req_wem[g*MW +: MW];
      assign addr_a[g]  = req_addr[g*AW +: AW];
      assign wdata_a[g] = req_wdata[g*DW +: DW];
   end

   // Enable flop: held low through reset, set on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en <= 1'b0;
      end else begin
         en <= 1'b1;
      end
   end

   // Round-robin search starting at ptr, wrapping modulo NREQ.
   always_comb begin
      logic [CW-1:0] cand;
      cand      = '0;
      gnt_found = 1'b0;
      gnt_idx   = ptr;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = CW'(ptr) + CW'(k);
         if (cand >= CW'(NREQ)) begin
            cand = cand - CW'(NREQ);
         end
         if (!gnt_found && req_valid[cand[IW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IW-1:0];
         end
      end
   end

   // Accept qualification, one-hot ready and next pointer value.
   always_comb begin
      accept             = en & gnt_found;
      rd_issue           = accept & ~req_we[gnt_idx];
      req_ready          = '0;
      req_ready[gnt_idx] = accept;
      ptr_inc            = CW'(gnt_idx) + CW'(1);
      if (ptr_inc >= CW'(NREQ)) begin
         ptr_inc = '0;
      end
   end

   // Round-robin pointer: advances past the winner only on an accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= ptr_inc[IW-1:0];
      end
   end

   // SRAM pin drive in the accept cycle; address/data follow the selected requester.
   always_comb begin
      sram_cs   = accept;
      sram_we   = accept & req_we[gnt_idx];
      sram_wem  = '0;
      if (accept && req_we[gnt_idx]) begin
         sram_wem = wem_a[gnt_idx];
      end
      sram_addr = addr_a[gnt_idx];
      sram_din  = wdata_a[gnt_idx];
   end

`ifdef SRAM_ARB_RDATA_REG_EN
   logic            rd_pend1;
   logic [IW-1:0]   rd_id1;
   logic [DW-1:0]   rdata_q;

   // Two-stage read tag pipeline; SRAM data is captured while stage one is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend1 <= 1'b0;
         rd_id1   <= '0;
         rd_pend  <= 1'b0;
         rd_id    <= '0;
         rdata_q  <= '0;
      end else begin
         rd_pend1 <= rd_issue;
         if (rd_issue) begin
            rd_id1 <= gnt_idx;
         end
         rd_pend <= rd_pend1;
         rd_id   <= rd_id1;
         if (rd_pend1) begin
            rdata_q <= sram_dout;
         end
      end
   end

   assign rsp_rdata = rdata_q;
`else
   // Single-stage read tag: SRAM output is valid the cycle after the accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend <= 1'b0;
         rd_id   <= '0;
      end else begin
         rd_pend <= rd_issue;
         if (rd_issue) begin
            rd_id <= gnt_idx;
         end
      end
   end

   assign rsp_rdata = sram_dout;
`endif

   // Decode the pending read tag into the one-hot response strobe.
   always_comb begin
      rsp_valid        = '0;
      rsp_valid[rd_id] = rd_pend;
   end

endmodule

// File: tb/tb_sram_arb.sv
// Directed testbench for sram_arb with a behavioural 4K x 64 SRAM model.
module tb_sram_arb;

`ifdef SRAM_ARB_RDATA_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk;
   logic          rst_n;
   logic [2:0]    req_valid;
   logic [2:0]    req_ready;
   logic [2:0]    req_we;
   logic [23:0]   req_wem;
   logic [35:0]   req_addr;
   logic [191:0]  req_wdata;
   logic [2:0]    rsp_valid;
   logic [63:0]   rsp_rdata;
   logic          sram_cs;
   logic          sram_we;
   logic [7:0]    sram_wem;
   logic [11:0]   sram_addr;
   logic [63:0]   sram_din;
   logic [63:0]   sram_dout;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   sram_arb #(.NREQ(3), .DW(64), .MW(8), .AW(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_wem   (req_wem),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .sram_cs   (sram_cs),
      .sram_we   (sram_we),
      .sram_wem  (sram_wem),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_dout (sram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: preset pattern {20'hCAFEF, addr, 32'hAAAAAAAA}, byte-masked writes, 1-cycle reads.
   logic [63:0] mem [4096];
   logic        init_done = 1'b0;
   always @(posedge clk) begin
      if (!init_done) begin
         for (int a = 0; a < 4096; a++) begin
            mem[a] <= {20'hCAFEF, 12'(a), 32'hAAAA_AAAA};
         end
         init_done <= 1'b1;
      end else if (sram_cs) begin
         if (sram_we) begin
            for (int b = 0; b < 8; b++) begin
               if (sram_wem[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
            end
         end else begin
            sram_dout <= mem[sram_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         fails = fails + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic we, input logic [7:0] wem,
                          input logic [11:0] a, input logic [63:0] d);
      req_valid[i]          = v;
      req_we[i]             = we;
      req_wem[i*8 +: 8]     = wem;
      req_addr[i*12 +: 12]  = a;
      req_wdata[i*64 +: 64] = d;
   endtask

   // Called in cycle T+1 after a read accept at edge T; leaves time one cycle after the response.
   task automatic expect_rsp(input string tag, input logic [2:0] oh, input logic [63:0] d);
`ifdef SRAM_ARB_RDATA_REG_EN
      chk({tag, "_early"}, 64'(rsp_valid), 64'(3'b000));
      tick();
`endif
      chk({tag, "_valid"}, 64'(rsp_valid), 64'(oh));
      chk({tag, "_data"}, rsp_rdata, d);
      tick();
      chk({tag, "_after"}, 64'(rsp_valid), 64'(3'b000));
`ifdef SRAM_ARB_RDATA_REG_EN
      chk({tag, "_hold"}, rsp_rdata, d);
`endif
   endtask

   logic [63:0] fdata [3];
   int          cnt [3];
   logic [2:0]  oh;
   int          g;

   initial begin
      fdata[0] = 64'hCAFE_F010_AAAA_AAAA;
      fdata[1] = 64'hCAFE_F011_AAAA_AAAA;
      fdata[2] = 64'hCAFE_F012_AAAA_AAAA;
      cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
      rst_n = 1'b0;
      req_valid = '0; req_we = '0; req_wem = '0; req_addr = '0; req_wdata = '0;

      // Reset with every requester asking for a read.
      for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 8'h00, 12'(12'h010 + i), 64'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_ready", 64'(req_ready), 64'(3'b000));
         chk("rst_cs", 64'(sram_cs), 64'(1'b0));
         chk("rst_rsp", 64'(rsp_valid), 64'(3'b000));
      end
      rst_n = 1'b1;
      #1;
      chk("rel_ready", 64'(req_ready), 64'(3'b000));
      chk("rel_cs", 64'(sram_cs), 64'(1'b0));
      tick();
      chk("en_ready", 64'(req_ready), 64'(3'b001));
      chk("en_cs", 64'(sram_cs), 64'(1'b1));
      req_valid = '0;
      #1;
      chk("drop_ready", 64'(req_ready), 64'(3'b000));
      chk("drop_cs", 64'(sram_cs), 64'(1'b0));
      chk("drop_we", 64'(sram_we), 64'(1'b0));
      chk("drop_wem", 64'(sram_wem), 64'(8'h00));

      // Masked write followed by read of the same word.
      set_req(0, 1'b1, 1'b1, 8'h0F, 12'h0A5, 64'h1122_3344_5566_7788);
      #1;
      chk("wr_ready", 64'(req_ready), 64'(3'b001));
      chk("wr_cs", 64'(sram_cs), 64'(1'b1));
      chk("wr_we", 64'(sram_we), 64'(1'b1));
      chk("wr_wem", 64'(sram_wem), 64'(8'h0F));
      chk("wr_addr", 64'(sram_addr), 64'(12'h0A5));
      chk("wr_din", sram_din, 64'h1122_3344_5566_7788);
      tick();
      set_req(0, 1'b1, 1'b0, 8'hFF, 12'h0A5, 64'h0);
      #1;
      chk("rd_ready", 64'(req_ready), 64'(3'b001));
      chk("rd_we", 64'(sram_we), 64'(1'b0));
      chk("rd_wem", 64'(sram_wem), 64'(8'h00));
      tick();
      req_valid = '0;
      #1;
      expect_rsp("wr_rd", 3'b001, 64'hCAFE_F0A5_5566_7788);

      // Mid-operation reset: ptr is 1, read from req1 is accepted then reset hits.
      set_req(1, 1'b1, 1'b0, 8'h00, 12'h011, 64'h0);
      #1;
      chk("mrst_ready", 64'(req_ready), 64'(3'b010));
      tick();
      rst_n = 1'b0;
      req_valid = '0;
      #1;
      chk("mrst_rsp0", 64'(rsp_valid), 64'(3'b000));
      tick();
      chk("mrst_rsp1", 64'(rsp_valid), 64'(3'b000));
      rst_n = 1'b1;
      tick();
      chk("mrst_rsp2", 64'(rsp_valid), 64'(3'b000));

      // Fairness: all three read continuously for six grants; ptr must restart at 0.
      for (int k = 0; k < 6 + LAT; k++) begin
         if (k < 6) begin
            for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 8'h00, 12'(12'h010 + i), 64'h0);
         end else begin
            req_valid = '0;
         end
         #1;
         oh = (k < 6) ? 3'(1 << (k % 3)) : 3'b000;
         chk("fair_ready", 64'(req_ready), 64'(oh));
         if (k >= LAT) begin
            g  = (k - LAT) % 3;
            oh = 3'(1 << g);
            chk("fair_rsp_valid", 64'(rsp_valid), 64'(oh));
            chk("fair_rsp_data", rsp_rdata, fdata[g]);
         end else begin
            chk("fair_rsp_idle", 64'(rsp_valid), 64'(3'b000));
         end
         for (int b = 0; b < 3; b++) if (rsp_valid[b]) cnt[b] = cnt[b] + 1;
         tick();
      end
      for (int b = 0; b < 3; b++) chk("fair_count", 64'(cnt[b]), 64'd2);

      // Sparse: only req2 at ptr=0, then req1+req2 -> req1 first, then req2.
      set_req(2, 1'b1, 1'b0, 8'h00, 12'h012, 64'h0);
      #1;
      chk("sparse_r2", 64'(req_ready), 64'(3'b100));
      tick();
      set_req(1, 1'b1, 1'b0, 8'h00, 12'h011, 64'h0);
      #1;
      chk("sparse_r1", 64'(req_ready), 64'(3'b010));
`ifndef SRAM_ARB_RDATA_REG_EN
      chk("sparse_rsp2", 64'(rsp_valid), 64'(3'b100));
      chk("sparse_dat2", rsp_rdata, fdata[2]);
`endif
      tick();
      #1;
      chk("sparse_r2b", 64'(req_ready), 64'(3'b100));
      tick();
      req_valid = '0;
      tick();
      tick();

      // Write with empty mask still issues an access but must not change the word.
      set_req(1, 1'b1, 1'b1, 8'h00, 12'h0A5, 64'hFFFF_FFFF_FFFF_FFFF);
      #1;
      chk("wem0_ready", 64'(req_ready), 64'(3'b010));
      chk("wem0_cs", 64'(sram_cs), 64'(1'b1));
      chk("wem0_we", 64'(sram_we), 64'(1'b1));
      chk("wem0_wem", 64'(sram_wem), 64'(8'h00));
      tick();
      set_req(1, 1'b1, 1'b0, 8'h00, 12'h0A5, 64'h0);
      #1;
      chk("wem0_rd_ready", 64'(req_ready), 64'(3'b010));
      tick();
      req_valid = '0;
      #1;
      expect_rsp("wem0_rd", 3'b010, 64'hCAFE_F0A5_5566_7788);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
